addr_sequencer: RTL

ADDR_SEQUENCER -- requirements
Module: addr_sequencer

---
 rtl/addr_sequencer_if.sv | 41 ++++
 rtl/addr_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/addr_sequencer_if.sv
// addr_sequencer_if
//   Control and status bundle for addr_sequencer.
//   master : drives start/stop/pause/mode/start_addr/end_addr, observes status
//   slave  : the sequencer itself
//   start, stop    one-cycle requests
//   pause          level, freezes a running sequence
//   mode [1:0]     0/3 loop, 1 one-shot, 2 ping-pong
//   start_addr     first address of the sequence
//   end_addr       last address of the sequence
//   addr           current address (registered)
//   busy           high while running
//   tick           pulse per step
//   wrap           pulse on loop wrap or ping-pong reversal
//   done           pulse on one-shot completion
//   err            pulse on rejected start
interface addr_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic              stop;
   logic              pause;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [ADDR_W-1:0] addr;
   logic              busy;
   logic              tick;
   logic              wrap;
   logic              done;
   logic              err;

   modport master (
      output start, stop, pause, mode, start_addr, end_addr,
      input  addr, busy, tick, wrap, done, err
   );

   modport slave (
      input  start, stop, pause, mode, start_addr, end_addr,
      output addr, busy, tick, wrap, done, err
   );
endinterface

// File: rtl/addr_sequencer.sv
// addr_sequencer
//   Steps an address through [start_addr, end_addr] at STEP_FREQ steps per
//   second, derived from sclk by a prescaler. Loop, one-shot and ping-pong
//   traversal. All status pulses are registered and last one cycle.
//   sclk  : system clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : addr_sequencer_if slave modport (controls in, status out)
//
//   state | meaning
//   IDLE  | waiting for start; addr holds its last value
//   RUN   | prescaler counting, addr stepping on each terminal count
module addr_sequencer #(
   parameter int CLK_FREQ  = 50000000,
   parameter int STEP_FREQ = 4,
   parameter int ADDR_W    = 16
) (
   input logic              sclk,
   input logic              nrst,
   addr_sequencer_if.slave  bus
);
   localparam int CNT_MAX = CLK_FREQ / STEP_FREQ - 1;
   localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CNT_MAX);

   localparam logic [1:0] MODE_ONESHOT  = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic              dir_up_q, dir_up_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic              tick_q, tick_d;
   logic              wrap_q, wrap_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         presc_q  <= '0;
         dir_up_q <= 1'b1;
         mode_q   <= '0;
         start_q  <= '0;
         end_q    <= '0;
         tick_q   <= 1'b0;
         wrap_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         presc_q  <= presc_d;
         dir_up_q <= dir_up_d;
         mode_q   <= mode_d;
         start_q  <= start_d;
         end_q    <= end_d;
         tick_q   <= tick_d;
         wrap_q   <= wrap_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      presc_d  = presc_q;
      dir_up_d = dir_up_q;
      mode_d   = mode_q;
      start_d  = start_q;
      end_d    = end_q;
      tick_d   = 1'b0;
      wrap_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.start_addr <= bus.end_addr) begin
                  mode_d   = bus.mode;
                  start_d  = bus.start_addr;
                  end_d    = bus.end_addr;
                  addr_d   = bus.start_addr;
                  presc_d  = '0;
                  dir_up_d = 1'b1;
                  state_d  = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         RUN: begin
            // stop wins over pause and over a coincident terminal count
            if (bus.stop) begin
               state_d = IDLE;
               presc_d = '0;
            end else if (!bus.pause) begin
               if (presc_q == CNT_TC) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  case (mode_q)
                     MODE_ONESHOT: begin
                        if (addr_q == end_q) begin
                           done_d  = 1'b1;
                           state_d = IDLE;
                        end else begin
                           addr_d = addr_q + ADDR_W'(1);
                        end
                     end
                     MODE_PINGPONG: begin
                        // a single-address range has nowhere to bounce to
                        if (start_q == end_q) begin
                           wrap_d = 1'b1;
                        end else if (dir_up_q) begin
                           if (addr_q == end_q) begin
                              dir_up_d = 1'b0;
                              addr_d   = end_q - ADDR_W'(1);
                              wrap_d   = 1'b1;
                           end else begin
                              addr_d = addr_q + ADDR_W'(1);
                           end
                        end else begin
                           if (addr_q == start_q) begin
                              dir_up_d = 1'b1;
                              addr_d   = start_q + ADDR_W'(1);
                              wrap_d   = 1'b1;
                           end else begin
                              addr_d = addr_q - ADDR_W'(1);
                           end
                        end
                     end
                     default: begin
                        if (addr_q == end_q) begin
                           addr_d = start_q;
                           wrap_d = 1'b1;
                        end else begin
                           addr_d = addr_q + ADDR_W'(1);
                        end
                     end
                  endcase
               end else begin
                  presc_d = presc_q + CNT_W'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.addr = addr_q;
   assign bus.busy = (state_q == RUN);
   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

endmodule
